fwd_hazard_ctrl: RTL
====================

// Module: fwd_hazard_ctrl
// PURPOSE
// - Operand-forwarding and load-use hazard controller for the 5-stage RISC-V core (IF/ID/EX/MEM/WB).
// - Tracks destination registers of in-flight instructions in EX, MEM and WB.
// - Produces registered 2-bit selects for the two EX-stage operand mux4_v1 instances, plus a 1-cycle
//   load-use stall to the IF/ID pipeline registers.
// - Sits in ID: decode feeds it; its selects drive the EX operand muxes in the following cycle.
// PARAMETERS
// - REG_ADDR_W  5   register-file address width
// - CNT_W       16  width of saturating stall counter
// PORTS
// - clk          in   1           core clock, rising edge
// - rst_n        in   1           async active-low reset
// - id_valid     in   1           ID holds a real instruction
// - id_rs1       in   REG_ADDR_W  source reg 1 of ID instr
// - id_rs2       in   REG_ADDR_W  source reg 2 of ID instr
// - id_rs1_used  in   1           instr reads rs1
// - id_rs2_used  in   1           instr reads rs2
// - id_rd        in   REG_ADDR_W  destination reg of ID instr
// - id_rd_we     in   1           instr writes rd
// - id_is_load   in   1           instr is a load (result available only at MEM end)
// - flush        in   1           branch/jump redirect resolved in EX; kill ID instr
// - fwd_sel_a    out  2           EX operand A mux4 select (00 regfile, 01 EX/MEM alu, 10 MEM/WB result, 11 WB bypass)
// - fwd_sel_b    out  2           EX operand B mux4 select, same encoding
// - stall        out  1           hold PC and IF/ID register this cycle (combinational)
// - stall_count  out  CNT_W       number of stall cycles since reset, saturating
// BEHAVIOUR
// - Tracker: three entries EX, MEM, WB, each {valid, rd, we, is_load}. Every posedge:
//   WB<=MEM, MEM<=EX, EX<=ID-entry if (id_valid & !stall & !flush), else EX<=bubble (valid=0).
// - Entry "hits" rsN iff valid & we & rd==rsN & rsN!=0 & rsN_used. x0 never forwarded.
// - Hazard: stall = id_valid & !flush & EX.valid & EX.is_load & (EX hits rs1 | EX hits rs2). Combinational.
// - Select compute (per operand, priority youngest first), evaluated in ID:
//   - EX hit (non-load) -> 01
//   - else MEM hit -> 10
//   - else WB hit -> per FWD_WB_BYPASS_EN
//   - else 00
// - fwd_sel_a/b are registered; they load the computed value when the ID instr advances into EX,
//   else load 00 (bubble). Latency: one cycle, aligned with the instr's EX cycle.
// - Load-use: on stall, EX gets bubble, ID holds. Next cycle the load is in MEM, the hit resolves to 10,
//   and stall deasserts. Exactly one stall cycle per load-use pair.
// - flush takes precedence over stall: stall=0, EX<=bubble, sel<=00. MEM/WB entries are not killed
//   (they are older than the branch).
// - Simultaneous hits in several stages: youngest wins. Both operands are evaluated independently.
// - stall_count increments on each cycle with stall=1, holds at all-ones.
// - Reset (async, rst_n=0): all entries invalid, fwd_sel_a/b=00, stall_count=0.
//   stall=0 follows since EX is invalid. Reset mid-operation discards all tracked state immediately;
//   first post-reset instr sees no hazards.
// CONFIGURATION
// - FWD_WB_BYPASS_EN defined: WB hit -> select 11 (WB result bypass path into mux input 4).
// - Not defined: WB hit -> 00; the regfile is write-through (same-cycle write visible on read).
//   Select 11 is never produced.
// TESTING
// - Reset: rst_n=0 mid-stream -> fwd_sel_a/b=00, stall=0, stall_count=0 immediately.
// - ALU chain: add x5 then add x6,x5,x1 back-to-back -> second instr's EX cycle fwd_sel_a=01, fwd_sel_b=00.
// - Load-use: lw x7 then add x8,x7,x7 -> stall=1 for exactly 1 cycle; add's EX fwd_sel_a=fwd_sel_b=10;
//   stall_count=1.
// - Distance 3: write x9, two unrelated instrs, then read x9 -> sel=11 with FWD_WB_BYPASS_EN, 00 without.
// - x0 and priority: writes to x0 never forwarded (sel 00). Writes to x4 in MEM and EX -> sel=01 (youngest).
// - Flush vs stall: load-use pair with flush=1 in the stall cycle -> stall=0, next EX sel=00, stall_count unchanged.

Source files
------------

// File: rtl/fwd_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_if
// Bundle between ID-stage decode and the forwarding / hazard controller.
//   master : decode side. Drives the ID instruction fields and flush, and
//            receives the operand selects, the stall and the stall counter.
//   slave  : controller side (fwd_hazard_ctrl).
// Signals:
//   id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
//   id_rd, id_rd_we, id_is_load        ID instruction description
//   flush                              redirect resolved in EX; kill the ID instruction
//   fwd_sel_a, fwd_sel_b               registered EX operand mux selects
//   stall                              combinational load-use stall
//   stall_count                        saturating count of stall cycles
// ---------------------------------------------------------------------------
interface fwd_hazard_ctrl_if #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
);
   logic                  id_valid;
   logic [REG_ADDR_W-1:0] id_rs1;
   logic [REG_ADDR_W-1:0] id_rs2;
   logic                  id_rs1_used;
   logic                  id_rs2_used;
   logic [REG_ADDR_W-1:0] id_rd;
   logic                  id_rd_we;
   logic                  id_is_load;
   logic                  flush;
   logic [1:0]            fwd_sel_a;
   logic [1:0]            fwd_sel_b;
   logic                  stall;
   logic [CNT_W-1:0]      stall_count;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_rd_we, id_is_load, flush,
      input  fwd_sel_a, fwd_sel_b, stall, stall_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_rd_we, id_is_load, flush,
      output fwd_sel_a, fwd_sel_b, stall, stall_count
   );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// Operand-forwarding and load-use hazard controller for a 5-stage core.
// The controller sits in ID. It tracks the destination registers of the
// instructions in EX, MEM and WB. It computes the EX operand mux selects for
// the ID instruction and registers them, so they take effect in that
// instruction's EX cycle. A load followed directly by a consumer raises a
// one-cycle combinational stall.
//
// Ports:
//   clk    in  core clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    fwd_hazard_ctrl_if.slave (ID instruction, flush, selects, stall,
//          stall_count)
//
// Select encoding: 00 regfile, 01 EX/MEM alu, 10 MEM/WB result, 11 WB bypass.
//
// Configuration macro FWD_WB_BYPASS_EN:
//   defined     a hit in WB selects 11 (dedicated WB bypass input)
//   undefined   a hit in WB selects 00, because the regfile is write-through;
//               select 11 is never produced
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
   parameter int REG_ADDR_W = 5,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   fwd_hazard_ctrl_if.slave  bus
);

   typedef struct packed {
      logic                  valid;
      logic                  we;
      logic [REG_ADDR_W-1:0] rd;
   } entry_t;

   localparam entry_t BUBBLE = '{valid: 1'b0, we: 1'b0, rd: {REG_ADDR_W{1'b0}}};

   localparam logic [1:0] SEL_RF  = 2'b00;
   localparam logic [1:0] SEL_ALU = 2'b01;
   localparam logic [1:0] SEL_MEM = 2'b10;
`ifdef FWD_WB_BYPASS_EN
   localparam logic [1:0] SEL_WB  = 2'b11;
`else
   localparam logic [1:0] SEL_WB  = 2'b00;
`endif

   entry_t           ex_r;
   entry_t           mem_r;
   entry_t           wb_r;
   logic             ex_load_r;
   logic [1:0]       sel_a_r;
   logic [1:0]       sel_b_r;
   logic [CNT_W-1:0] stall_count_r;

   entry_t           id_entry_s;
   logic             stall_s;
   logic             advance_s;
   logic [1:0]       sel_a_s;
   logic [1:0]       sel_b_s;

   // An entry hits a source only for a real, writing producer of a non-x0 register that is actually read.
   function automatic logic entry_hit(input entry_t e,
                                      input logic [REG_ADDR_W-1:0] rs,
                                      input logic used);
      entry_hit = e.valid & e.we & (e.rd == rs) & (rs != {REG_ADDR_W{1'b0}}) & used;
   endfunction

   // Youngest producer wins. A load in EX is not forwardable; that case stalls instead.
   function automatic logic [1:0] select_for(input entry_t ex, input logic ex_load,
                                             input entry_t mem, input entry_t wb,
                                             input logic [REG_ADDR_W-1:0] rs,
                                             input logic used);
      if (entry_hit(ex, rs, used) && !ex_load) begin
         select_for = SEL_ALU;
      end else if (entry_hit(mem, rs, used)) begin
         select_for = SEL_MEM;
      end else if (entry_hit(wb, rs, used)) begin
         select_for = SEL_WB;
      end else begin
         select_for = SEL_RF;
      end
   endfunction

   // ID-stage hazard detection and select computation.
   always_comb begin
      id_entry_s.valid = bus.id_valid;
      id_entry_s.we    = bus.id_rd_we;
      id_entry_s.rd    = bus.id_rd;

      stall_s = bus.id_valid & ~bus.flush & ex_r.valid & ex_load_r &
                (entry_hit(ex_r, bus.id_rs1, bus.id_rs1_used) |
                 entry_hit(ex_r, bus.id_rs2, bus.id_rs2_used));

      advance_s = bus.id_valid & ~stall_s & ~bus.flush;

      sel_a_s = select_for(ex_r, ex_load_r, mem_r, wb_r, bus.id_rs1, bus.id_rs1_used);
      sel_b_s = select_for(ex_r, ex_load_r, mem_r, wb_r, bus.id_rs2, bus.id_rs2_used);
   end

   // Pipeline tracker and registered selects. A stall or flush injects a bubble into EX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_r      <= BUBBLE;
         mem_r     <= BUBBLE;
         wb_r      <= BUBBLE;
         ex_load_r <= 1'b0;
         sel_a_r   <= SEL_RF;
         sel_b_r   <= SEL_RF;
      end else begin
         wb_r  <= mem_r;
         mem_r <= ex_r;
         if (advance_s) begin
            ex_r      <= id_entry_s;
            ex_load_r <= bus.id_is_load;
            sel_a_r   <= sel_a_s;
            sel_b_r   <= sel_b_s;
         end else begin
            ex_r      <= BUBBLE;
            ex_load_r <= 1'b0;
            sel_a_r   <= SEL_RF;
            sel_b_r   <= SEL_RF;
         end
      end
   end

   // Saturating count of stall cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_r <= {CNT_W{1'b0}};
      end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
         stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

   assign bus.fwd_sel_a   = sel_a_r;
   assign bus.fwd_sel_b   = sel_b_r;
   assign bus.stall       = stall_s;
   assign bus.stall_count = stall_count_r;

endmodule
